// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared playfield dimensions, colour type and game command codes
package tetris_pkg;

  localparam int ROWS = 22;
  localparam int COLS = 10;
  localparam int CW   = 3;

  typedef logic [CW-1:0] colour_t;

  typedef enum logic [2:0] {
    CMD_CHECK   = 3'b000,
    CMD_STEP    = 3'b001,
    CMD_WRITE   = 3'b010,
    CMD_SHIFT   = 3'b011,
    CMD_ADD     = 3'b100,
    CMD_LATERAL = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {
    GO_RUNNING = 2'b00,
    GO_SPAWN   = 2'b01,
    GO_LOCKED  = 2'b10
  } game_over_e;

  function automatic logic cell_in_range(input logic [4:0] r, input logic [3:0] c);
    return (int'(r) < ROWS) && (int'(c) < COLS);
  endfunction

endpackage

// File: rtl/board_collide.sv
// rtl/board_collide.sv - per-row landing detect and spawn overlap for the active piece
module board_collide
  import tetris_pkg::*;
(
  input  logic [ROWS-1:0][COLS-1:0] occ,
  input  logic [4:0]                pc_row [4],
  input  logic [3:0]                pc_col [4],
  input  logic                      pc_valid,
  output logic [ROWS-1:0]           stop_next,
  output logic                      overlap
);

  always_comb begin
    stop_next = '0;
    overlap   = 1'b0;
    if (pc_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (cell_in_range(pc_row[i], pc_col[i])) begin
          if (occ[pc_row[i]][pc_col[i]]) overlap = 1'b1;
          // Bottom row always lands; otherwise look at the cell directly below.
          if (pc_row[i] == 5'(ROWS - 1)) stop_next[pc_row[i]] = 1'b1;
          else if (occ[pc_row[i] + 5'd1][pc_col[i]]) stop_next[pc_row[i]] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/board_store.sv
// rtl/board_store.sv - playfield cell storage with piece write, row delete, line count and game-over tracking
module board_store
  import tetris_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      cmd,
  input  logic [ROWS-1:0] shift_row,
  input  logic [4:0]      pc_row [4],
  input  logic [3:0]      pc_col [4],
  input  logic [CW-1:0]   pc_colour,
  input  logic            pc_valid,
  output logic [ROWS-1:0] full_rows,
  output logic [ROWS-1:0] stop,
  output logic [1:0]      game_over,
  output logic [15:0]     lines,
  input  logic [4:0]      rd_row,
  input  logic [3:0]      rd_col,
  output logic [CW-1:0]   rd_cell
);

  colour_t                  board [ROWS][COLS];
  logic [ROWS-1:0][COLS-1:0] occ;
  logic [ROWS-1:0]          full_next;
  logic [ROWS-1:0]          stop_next;
  logic                     overlap;
  logic                     top_hit;
  logic [4:0]               shift_k;
  logic                     board_we;
  logic                     shift_en;
  game_over_e               go_q, go_d;

  always_comb begin
    occ       = '0;
    full_next = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) occ[r][c] = |board[r][c];
      full_next[r] = &occ[r];
    end
  end

  board_collide u_collide (
    .occ       (occ),
    .pc_row    (pc_row),
    .pc_col    (pc_col),
    .pc_valid  (pc_valid),
    .stop_next (stop_next),
    .overlap   (overlap)
  );

  // Highest set bit wins when several rows are requested at once.
  always_comb begin
    shift_k = '0;
    for (int r = 0; r < ROWS; r++)
      if (shift_row[r]) shift_k = 5'(r);
  end

  always_comb begin
    top_hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (pc_row[i] < 5'd2) top_hit = 1'b1;
  end

  always_comb begin
    go_d     = go_q;
    board_we = 1'b0;
    shift_en = 1'b0;
    case (go_q)
      GO_RUNNING: begin
        board_we = (cmd == CMD_WRITE) && pc_valid;
        shift_en = (cmd == CMD_SHIFT) && (|shift_row);
        if ((cmd == CMD_ADD) && pc_valid && overlap)
          go_d = GO_SPAWN;
        else if (board_we && top_hit)
          go_d = GO_LOCKED;
      end
      default: go_d = go_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) go_q <= GO_RUNNING;
    else       go_q <= go_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) board[r][c] <= '0;
    end else if (shift_en) begin
      for (int c = 0; c < COLS; c++) board[0][c] <= '0;
      for (int r = 1; r < ROWS; r++)
        if (5'(r) <= shift_k)
          for (int c = 0; c < COLS; c++) board[r][c] <= board[r-1][c];
    end else if (board_we) begin
      for (int i = 0; i < 4; i++)
        if (cell_in_range(pc_row[i], pc_col[i]))
          board[pc_row[i]][pc_col[i]] <= pc_colour;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_rows <= '0;
      stop      <= '0;
      lines     <= '0;
    end else begin
      full_rows <= full_next;
      stop      <= stop_next;
      if (shift_en && (lines != 16'hFFFF)) lines <= lines + 16'd1;
    end
  end

  assign game_over = go_q;
  assign rd_cell   = cell_in_range(rd_row, rd_col) ? board[rd_row][rd_col] : '0;

endmodule
